// File: rtl/rriot_pkg.sv
// Shared constants and types for the RRIOT interval timer.
package rriot_pkg;

    // Prescale periods selected by A[1:0] on a timer write
    localparam int DIV0 = 1;
    localparam int DIV1 = 8;
    localparam int DIV2 = 64;
    localparam int DIV3 = 1024;

    // Address bits inside the timer window
    localparam int A_RSEL_BIT = 0;  // read: 0 = count, 1 = flag
    localparam int A_WIN_BIT  = 2;  // write: 1 = load timer, 0 = ignored
    localparam int A_IEN_BIT  = 3;  // irq enable carried by writes and count reads

    typedef enum logic [1:0] {
        DIV_SEL_1    = 2'b00,
        DIV_SEL_8    = 2'b01,
        DIV_SEL_64   = 2'b10,
        DIV_SEL_1024 = 2'b11
    } div_sel_t;

    // Timer mode: stopped until first load, prescaled until underflow, then fast
    typedef enum logic [1:0] {
        MODE_STOP     = 2'b00,
        MODE_PRESCALE = 2'b01,
        MODE_FAST     = 2'b10
    } mode_t;

endpackage

// File: rtl/rriot_prescaler.sv
// Prescale down-counter: loads on a timer write, counts down while enabled,
// and reloads itself with the period minus one each time it reaches zero.
module rriot_prescaler #(
    parameter int PRE_W = 10
) (
    input  logic             phi2,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [PRE_W-1:0] load_val,
    input  logic [PRE_W-1:0] reload_val,
    output logic             tick
);

    logic [PRE_W-1:0] pre;

    // Tick marks the cycle in which the main count is allowed to step
    assign tick = en & (pre == '0);

    // Down-count with load priority; reload on zero so pre never goes below 0
    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else if (load) begin
            pre <= load_val;
        end else if (en) begin
            if (pre == '0) pre <= reload_val;
            else           pre <= pre - 1'b1;
        end
    end

endmodule

// File: rtl/rriot_timer_ctrl.sv
// Interval timer and IRQ controller for the 6530 replacement: holds the 8-bit
// count, underflow flag, timer mode and PB7 irq takeover state.
module rriot_timer_ctrl
    import rriot_pkg::*;
#(
    parameter int PRE_W = 10
) (
    input  logic       phi2,
    input  logic       rst_n,
    input  logic       tsel,
    input  logic       we_n,
    input  logic [3:0] a,
    input  logic [7:0] di,
    output logic [7:0] rdata,
    output logic       irq,
    output logic       irq_en
);

    mode_t      mode, nxt_mode;
    div_sel_t   div, nxt_div, load_sel;
    logic [7:0] count, nxt_count;
    logic       flag, nxt_flag, nxt_irq_en;
    logic       wr, rd_count, tick;
    logic [PRE_W-1:0] pre_load_val, pre_reload_val;

    function automatic logic [PRE_W-1:0] period_m1(input div_sel_t sel);
        case (sel)
            DIV_SEL_1:    period_m1 = PRE_W'(DIV0 - 1);
            DIV_SEL_8:    period_m1 = PRE_W'(DIV1 - 1);
            DIV_SEL_64:   period_m1 = PRE_W'(DIV2 - 1);
            default:      period_m1 = PRE_W'(DIV3 - 1);
        endcase
    endfunction

    assign wr             = tsel & ~we_n & a[A_WIN_BIT];
    assign rd_count       = tsel & we_n & ~a[A_RSEL_BIT];
    assign load_sel       = div_sel_t'(a[1:0]);
    assign pre_load_val   = period_m1(load_sel);
    assign pre_reload_val = period_m1(div);

    rriot_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .phi2       (phi2),
        .rst_n      (rst_n),
        .load       (wr),
        .en         ((mode == MODE_PRESCALE) & ~wr),
        .load_val   (pre_load_val),
        .reload_val (pre_reload_val),
        .tick       (tick)
    );

    // Read mux: count or flag bit, zero when the timer window is not selected
    always_comb begin
        rdata = 8'h00;
        if (tsel) rdata = a[A_RSEL_BIT] ? {flag, 7'b0} : count;
    end

    // Next-state: a write overrides everything; underflow flag-set beats a count-read clear
    always_comb begin
        nxt_mode   = mode;
        nxt_div    = div;
        nxt_count  = count;
        nxt_flag   = flag;
        nxt_irq_en = irq_en;
        if (wr) begin
            nxt_count  = di;
            nxt_div    = load_sel;
            nxt_mode   = MODE_PRESCALE;
            nxt_flag   = 1'b0;
            nxt_irq_en = a[A_IEN_BIT];
        end else begin
            if (rd_count) begin
                nxt_flag   = 1'b0;
                nxt_irq_en = a[A_IEN_BIT];
            end
            if (mode == MODE_FAST) begin
                nxt_count = count - 8'd1;
            end else if (tick) begin
                if (count != 8'h00) begin
                    nxt_count = count - 8'd1;
                end else begin
                    nxt_count = 8'hFF;
                    nxt_flag  = 1'b1;
                    nxt_mode  = MODE_FAST;
                end
            end
        end
    end

    // State registers; irq is registered from next state so PB7 never glitches
    always_ff @(posedge phi2 or negedge rst_n) begin
        if (!rst_n) begin
            mode   <= MODE_STOP;
            div    <= DIV_SEL_1;
            count  <= 8'h00;
            flag   <= 1'b0;
            irq_en <= 1'b0;
            irq    <= 1'b1;
        end else begin
            mode   <= nxt_mode;
            div    <= nxt_div;
            count  <= nxt_count;
            flag   <= nxt_flag;
            irq_en <= nxt_irq_en;
            irq    <= ~(nxt_flag & nxt_irq_en);
        end
    end

endmodule

// File: tb/tb_rriot_timer_ctrl.sv
// Directed bench for rriot_timer_ctrl with hand-computed expectations.
module tb_rriot_timer_ctrl;

    logic       phi2 = 1'b0;
    logic       rst_n = 1'b0;
    logic       tsel = 1'b0;
    logic       we_n = 1'b1;
    logic [3:0] a = 4'h0;
    logic [7:0] di = 8'h00;
    logic [7:0] rdata;
    logic       irq;
    logic       irq_en;

    int n_checks = 0;
    int n_pass   = 0;

    rriot_timer_ctrl dut (
        .phi2   (phi2),
        .rst_n  (rst_n),
        .tsel   (tsel),
        .we_n   (we_n),
        .a      (a),
        .di     (di),
        .rdata  (rdata),
        .irq    (irq),
        .irq_en (irq_en)
    );

    // Clock
    always #5 phi2 = ~phi2;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one
    task automatic cycles(input int n);
        repeat (n) @(posedge phi2);
        #1;
    endtask

    // Timer write that lands on the next rising edge (the load edge)
    task automatic wr(input logic [3:0] av, input logic [7:0] dv);
        @(negedge phi2);
        tsel = 1'b1; we_n = 1'b0; a = av; di = dv;
        @(posedge phi2);
        #1;
        tsel = 1'b0; we_n = 1'b1;
    endtask

    // Combinational peeks between edges (no edge occurs, so no side effects)
    task automatic peek_count(output logic [7:0] v);
        tsel = 1'b1; we_n = 1'b1; a = 4'b0000; #1; v = rdata; tsel = 1'b0;
    endtask

    task automatic peek_flag(output logic [7:0] v);
        tsel = 1'b1; we_n = 1'b1; a = 4'b0001; #1; v = rdata; tsel = 1'b0;
    endtask

    // Count read that spans a rising edge; returns the pre-edge rdata
    task automatic rd_count_edge(input logic [3:0] av, output logic [7:0] v);
        @(negedge phi2);
        tsel = 1'b1; we_n = 1'b1; a = av;
        #1; v = rdata;
        @(posedge phi2);
        #1;
        tsel = 1'b0;
    endtask

    logic [7:0] v;

    initial begin
        // Reset state
        #12;
        check("rst_irq", {7'b0, irq}, 8'h01);
        check("rst_irq_en", {7'b0, irq_en}, 8'h00);
        peek_count(v); check("rst_count", v, 8'h00);
        rst_n = 1'b1;
        cycles(5);
        peek_flag(v); check("stopped_flag", v, 8'h00);
        peek_count(v); check("stopped_count", v, 8'h00);

        // DIV0, di=03, irq enabled: flag at edge 4
        wr(4'b1100, 8'h03);
        peek_count(v); check("div0_load_count", v, 8'h03);
        check("div0_irq_en", {7'b0, irq_en}, 8'h01);
        cycles(3);
        peek_count(v); check("div0_e3_count", v, 8'h00);
        peek_flag(v); check("div0_e3_flag", v, 8'h00);
        check("div0_e3_irq", {7'b0, irq}, 8'h01);
        cycles(1);
        peek_flag(v); check("div0_e4_flag", v, 8'h80);
        check("div0_e4_irq", {7'b0, irq}, 8'h00);
        peek_count(v); check("div0_e4_count", v, 8'hFF);
        cycles(1);
        peek_count(v); check("fast_count", v, 8'hFE);

        // Count read with A3=1 clears flag, keeps fast mode
        rd_count_edge(4'b1000, v); check("rd_value", v, 8'hFE);
        peek_flag(v); check("rd_flag_clr", v, 8'h00);
        check("rd_irq", {7'b0, irq}, 8'h01);
        check("rd_irq_en", {7'b0, irq_en}, 8'h01);
        peek_count(v); check("rd_count_after", v, 8'hFD);
        cycles(1);
        peek_count(v); check("fast_continue", v, 8'hFC);

        // Asynchronous reset mid-count
        #2; rst_n = 1'b0; #1;
        check("arst_irq", {7'b0, irq}, 8'h01);
        check("arst_irq_en", {7'b0, irq_en}, 8'h00);
        peek_count(v); check("arst_count", v, 8'h00);
        @(negedge phi2); rst_n = 1'b1;
        cycles(10);
        peek_flag(v); check("arst_no_flag", v, 8'h00);

        // DIV1, di=02, irq disabled: flag at edge 24, irq stays 1
        wr(4'b0101, 8'h02);
        check("div1_irq_en", {7'b0, irq_en}, 8'h00);
        cycles(23);
        peek_flag(v); check("div1_e23_flag", v, 8'h00);
        peek_count(v); check("div1_e23_count", v, 8'h00);
        cycles(1);
        peek_flag(v); check("div1_e24_flag", v, 8'h80);
        check("div1_e24_irq", {7'b0, irq}, 8'h01);
        peek_count(v); check("div1_e24_count", v, 8'hFF);

        // Underflow coincident with count read: flag set wins
        wr(4'b0100, 8'h01);
        cycles(1);
        rd_count_edge(4'b1000, v); check("coinc_rd_value", v, 8'h00);
        peek_flag(v); check("coinc_rd_flag", v, 8'h80);
        peek_count(v); check("coinc_rd_count", v, 8'hFF);
        check("coinc_rd_irq", {7'b0, irq}, 8'h00);

        // Underflow coincident with write: write wins
        wr(4'b0100, 8'h01);
        cycles(1);
        wr(4'b0100, 8'h10);
        peek_flag(v); check("coinc_wr_flag", v, 8'h00);
        peek_count(v); check("coinc_wr_count", v, 8'h10);
        cycles(1);
        peek_count(v); check("coinc_wr_step", v, 8'h0F);

        // Write with A2=0 is ignored
        wr(4'b0000, 8'h55);
        peek_count(v); check("ignored_wr", v, 8'h0E);

        // DIV3, di=00: flag exactly 1024 cycles after load
        wr(4'b0111, 8'h00);
        cycles(1023);
        peek_flag(v); check("div3_e1023_flag", v, 8'h00);
        cycles(1);
        peek_flag(v); check("div3_e1024_flag", v, 8'h80);
        peek_count(v); check("div3_e1024_count", v, 8'hFF);

        // rdata is zero when the window is not selected
        tsel = 1'b0; we_n = 1'b1; a = 4'b0001; #1;
        check("no_tsel_rdata", rdata, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
